// File: rtl/counter_slice_scheduler.sv
// Round-robin time-slice scheduler: one increment engine shared by two counters.
// Latency: grant one edge after req is sampled in IDLE; increments start on the following edge.
// Backpressure: level-sensitive req; contention yields after QUANTUM increments, no bubble on handoff.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   req[1:0]        increment request for counter1 (bit 0) / counter2 (bit 1)
//   clr[1:0]        synchronous clear of counter1 / counter2, wins over an increment
//   grant[1:0]      one-hot owner of the increment engine, 00 when idle
//   counter1/2      channel counts, modulo LIMIT
//   wrap[1:0]       one-cycle pulse when a counter wraps LIMIT-1 -> 0 by increment
//   active          high while any grant is held
module counter_slice_scheduler #(
  parameter int WIDTH   = 4,
  parameter int LIMIT   = 8,
  parameter int QUANTUM = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       clr,
  output logic [1:0]       grant,
  output logic [WIDTH-1:0] counter1,
  output logic [WIDTH-1:0] counter2,
  output logic [1:0]       wrap,
  output logic             active
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SERVE = 1'b1;

  // A quantum of 1 still needs a one-bit slice register.
  localparam int SW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

  localparam logic [WIDTH-1:0] CNT_MAX    = WIDTH'(LIMIT - 1);
  localparam logic [SW-1:0]    SLICE_LAST = SW'(QUANTUM - 1);

  logic [0:0]    state;
  logic          owner;
  logic          last;
  logic [SW-1:0] slice;

  logic          own_req;
  logic          other_req;
  logic          inc;
  logic          inc0;
  logic          inc1;
  logic          slice_end;

  // Request of the current owner drives the increment; the other channel's
  // request only matters for deciding whether to hand off.
  assign own_req   = req[owner];
  assign other_req = req[~owner];
  assign inc       = (state == SERVE) && own_req;
  assign inc0      = inc && !owner;
  assign inc1      = inc && owner;
  assign slice_end = (slice == SLICE_LAST);

  function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] v);
    return (v == CNT_MAX) ? '0 : v + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;          // channel 0 wins the first tie
      slice <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= SERVE;
            slice <= '0;
            // On a tie the channel not served most recently goes first.
            owner <= (req == 2'b11) ? ~last : req[1];
          end
        end
        SERVE: begin
          if (!own_req) begin
            // Owner released: hand over immediately or fall back to IDLE.
            last  <= owner;
            slice <= '0;
            if (other_req) begin
              owner <= ~owner;
            end else begin
              state <= IDLE;
            end
          end else if (slice_end) begin
            // Quantum used up: yield only if the other channel is waiting.
            slice <= '0;
            if (other_req) begin
              last  <= owner;
              owner <= ~owner;
            end
          end else begin
            slice <= slice + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          slice <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Counters and wrap pulses. A clear takes the counter but leaves the FSM
  // treating the cycle as a normal increment, so slicing is unaffected.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter1 <= '0;
      counter2 <= '0;
      wrap     <= 2'b00;
    end else begin
      if (clr[0]) begin
        counter1 <= '0;
      end else if (inc0) begin
        counter1 <= bump(counter1);
      end

      if (clr[1]) begin
        counter2 <= '0;
      end else if (inc1) begin
        counter2 <= bump(counter2);
      end

      wrap[0] <= inc0 && !clr[0] && (counter1 == CNT_MAX);
      wrap[1] <= inc1 && !clr[1] && (counter2 == CNT_MAX);
    end
  end

  // Outputs decode flops only; nothing combinational from req or clr.
  assign grant  = (state == SERVE) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign active = (state == SERVE);

endmodule

// File: tb/tb_counter_slice_scheduler.sv
// Directed, table-driven bench for counter_slice_scheduler (WIDTH 4, LIMIT 8, QUANTUM 4).
// Each table row: optional reset, inputs for one edge, expected outputs after that edge.
// Hand-written sequences cover async reset, early release and clear collision.
module tb_counter_slice_scheduler;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] clr;
  logic [1:0] grant;
  logic [3:0] counter1;
  logic [3:0] counter2;
  logic [1:0] wrap;
  logic       active;

  int n_cmp;
  int n_bad;

  counter_slice_scheduler #(
    .WIDTH  (4),
    .LIMIT  (8),
    .QUANTUM(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .clr     (clr),
    .grant   (grant),
    .counter1(counter1),
    .counter2(counter2),
    .wrap    (wrap),
    .active  (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] clr;
    logic [1:0] grant;
    logic [3:0] c1;
    logic [3:0] c2;
    logic [1:0] wrap;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rst, input logic [1:0] rq, input logic [1:0] cl,
                     input logic [1:0] g, input logic [3:0] c1, input logic [3:0] c2,
                     input logic [1:0] w);
    vec_t v;
    v.rst = rst; v.req = rq; v.clr = cl; v.grant = g; v.c1 = c1; v.c2 = c2; v.wrap = w;
    vt.push_back(v);
  endtask

  function automatic logic [12:0] obs();
    return {grant, counter1, counter2, wrap, active};
  endfunction

  function automatic logic [12:0] pk(input logic [1:0] g, input logic [3:0] c1,
                                     input logic [3:0] c2, input logic [1:0] w);
    return {g, c1, c2, w, |g};
  endfunction

  task automatic check(input string nm, input logic [12:0] got, input logic [12:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got grant=%b c1=%0d c2=%0d wrap=%b active=%b, want grant=%b c1=%0d c2=%0d wrap=%b active=%b",
               nm, got[12:11], got[10:7], got[6:3], got[2:1], got[0],
               exp[12:11], exp[10:7], exp[6:3], exp[2:1], exp[0]);
    end
  endtask

  task automatic do_reset();
    req   = 2'b00;
    clr   = 2'b00;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic [1:0] rq, input logic [1:0] cl);
    req = rq;
    clr = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    req   = 2'b00;
    clr   = 2'b00;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_state", obs(), pk(2'b00, 4'd0, 4'd0, 2'b00));

    // Solo requester on channel 0: no yield at the quantum, wraps after 8.
    add(1, 2'b01, 2'b00, 2'b01, 4'd0, 4'd0, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 4'd1, 4'd0, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 4'd2, 4'd0, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 4'd3, 4'd0, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 4'd4, 4'd0, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 4'd5, 4'd0, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 4'd6, 4'd0, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 4'd7, 4'd0, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 4'd0, 4'd0, 2'b01);
    add(0, 2'b01, 2'b00, 2'b01, 4'd1, 4'd0, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 4'd2, 4'd0, 2'b00);
    // Release to IDLE with last=0, then a tie goes to channel 1.
    add(0, 2'b00, 2'b00, 2'b00, 4'd2, 4'd0, 2'b00);
    add(0, 2'b11, 2'b00, 2'b10, 4'd2, 4'd0, 2'b00);
    // Continuous contention from reset: 4 increments each, alternating.
    add(1, 2'b11, 2'b00, 2'b01, 4'd0, 4'd0, 2'b00);
    add(0, 2'b11, 2'b00, 2'b01, 4'd1, 4'd0, 2'b00);
    add(0, 2'b11, 2'b00, 2'b01, 4'd2, 4'd0, 2'b00);
    add(0, 2'b11, 2'b00, 2'b01, 4'd3, 4'd0, 2'b00);
    add(0, 2'b11, 2'b00, 2'b10, 4'd4, 4'd0, 2'b00);
    add(0, 2'b11, 2'b00, 2'b10, 4'd4, 4'd1, 2'b00);
    add(0, 2'b11, 2'b00, 2'b10, 4'd4, 4'd2, 2'b00);
    add(0, 2'b11, 2'b00, 2'b10, 4'd4, 4'd3, 2'b00);
    add(0, 2'b11, 2'b00, 2'b01, 4'd4, 4'd4, 2'b00);
    add(0, 2'b11, 2'b00, 2'b01, 4'd5, 4'd4, 2'b00);
    add(0, 2'b11, 2'b00, 2'b01, 4'd6, 4'd4, 2'b00);
    add(0, 2'b11, 2'b00, 2'b01, 4'd7, 4'd4, 2'b00);
    add(0, 2'b11, 2'b00, 2'b10, 4'd0, 4'd4, 2'b01);
    add(0, 2'b11, 2'b00, 2'b10, 4'd0, 4'd5, 2'b00);
    add(0, 2'b11, 2'b00, 2'b10, 4'd0, 4'd6, 2'b00);
    add(0, 2'b11, 2'b00, 2'b10, 4'd0, 4'd7, 2'b00);
    add(0, 2'b11, 2'b00, 2'b01, 4'd0, 4'd0, 2'b10);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rst) do_reset();
      step(vt[i].req, vt[i].clr);
      check($sformatf("vec%0d", i), obs(), pk(vt[i].grant, vt[i].c1, vt[i].c2, vt[i].wrap));
    end

    // Async reset mid-SERVE: outputs clear before the next clock edge.
    do_reset();
    step(2'b01, 2'b00);
    step(2'b01, 2'b00);
    step(2'b01, 2'b00);
    step(2'b01, 2'b00);
    check("pre_reset_c1_3", obs(), pk(2'b01, 4'd3, 4'd0, 2'b00));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", obs(), pk(2'b00, 4'd0, 4'd0, 2'b00));
    #2;
    rst_n = 1'b1;
    step(2'b01, 2'b00);
    check("post_reset_grant", obs(), pk(2'b01, 4'd0, 4'd0, 2'b00));

    // Early release: two increments then drop to IDLE.
    do_reset();
    step(2'b01, 2'b00);
    step(2'b01, 2'b00);
    step(2'b01, 2'b00);
    step(2'b00, 2'b00);
    check("early_release", obs(), pk(2'b00, 4'd2, 4'd0, 2'b00));
    // From IDLE a new request only grants; no increment on the grant edge.
    step(2'b10, 2'b00);
    check("idle_regrant", obs(), pk(2'b10, 4'd2, 4'd0, 2'b00));

    // Clear colliding with an increment at counter1 = 7.
    do_reset();
    step(2'b01, 2'b00);
    for (int k = 0; k < 7; k++) step(2'b01, 2'b00);
    check("pre_clear_c1_7", obs(), pk(2'b01, 4'd7, 4'd0, 2'b00));
    step(2'b01, 2'b01);
    check("clear_collision", obs(), pk(2'b01, 4'd0, 4'd0, 2'b00));
    // Slice wrapped to 0 on the clear edge, so channel 0 keeps 4 more increments.
    step(2'b11, 2'b00);
    check("clear_slice_a", obs(), pk(2'b01, 4'd1, 4'd0, 2'b00));
    step(2'b11, 2'b00);
    step(2'b11, 2'b00);
    step(2'b11, 2'b00);
    check("clear_slice_b", obs(), pk(2'b10, 4'd4, 4'd0, 2'b00));
    // Clearing the non-owner counter while the owner advances.
    step(2'b11, 2'b00);
    step(2'b11, 2'b01);
    check("clear_non_owner", obs(), pk(2'b10, 4'd0, 4'd2, 2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Grant must never have both bits high.
  always @(negedge clk) begin
    if (rst_n && grant == 2'b11) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant_onehot: got grant=%b, want at most one bit", grant);
    end
  end

endmodule
